// File: rtl/vga_timing_gen.sv
// Parameterised VGA raster timing generator: pixel/line counters, sync, blanking,
// line/frame strobes and a completed-frame counter, all registered on one edge.
module vga_timing_gen #(
    parameter int     H_ACTIVE = 1024,
    parameter int     H_FP     = 24,
    parameter int     H_SYNC   = 136,
    parameter int     H_BP     = 160,
    parameter int     V_ACTIVE = 768,
    parameter int     V_FP     = 3,
    parameter int     V_SYNC   = 6,
    parameter int     V_BP     = 29,
    parameter bit     HS_POL   = 1'b0,
    parameter bit     VS_POL   = 1'b0,
    parameter int     CNT_W    = 11,
    parameter int     FRAME_W  = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_ce,
    output logic [CNT_W-1:0]   o_hcount,
    output logic [CNT_W-1:0]   o_vcount,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_hblnk,
    output logic               o_vblnk,
    output logic               o_line_start,
    output logic               o_frame_start,
    output logic [FRAME_W-1:0] o_frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
            V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0 ||
            (2 ** CNT_W) < H_TOTAL || (2 ** CNT_W) < V_TOTAL) begin : g_bad_cfg
            $error("vga_timing_gen: zero timing field or CNT_W too narrow");
        end
    endgenerate

    logic [CNT_W-1:0]   r_hcount, r_vcount;
    logic               r_hsync, r_vsync, r_hblnk, r_vblnk;
    logic               r_line_start, r_frame_start;
    logic [FRAME_W-1:0] r_frame_cnt;

    logic               w_h_wrap, w_v_wrap;
    logic [CNT_W-1:0]   w_h_nxt, w_v_nxt;

    // Sync/blank are decoded from the next counts so they line up with the
    // counter values presented on the same edge.
    always_comb begin
        w_h_wrap = (r_hcount == H_LAST);
        w_v_wrap = w_h_wrap && (r_vcount == V_LAST);
        w_h_nxt  = w_h_wrap ? '0 : r_hcount + 1'b1;
        w_v_nxt  = r_vcount;
        if (w_h_wrap) begin
            w_v_nxt = w_v_wrap ? '0 : r_vcount + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_hblnk       <= 1'b0;
            r_vblnk       <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (i_ce) begin
                r_hcount      <= w_h_nxt;
                r_vcount      <= w_v_nxt;
                r_hsync       <= (w_h_nxt >= HS_BEG && w_h_nxt < HS_END) ? HS_POL : ~HS_POL;
                r_vsync       <= (w_v_nxt >= VS_BEG && w_v_nxt < VS_END) ? VS_POL : ~VS_POL;
                r_hblnk       <= (w_h_nxt >= H_VIS);
                r_vblnk       <= (w_v_nxt >= V_VIS);
                r_line_start  <= w_h_wrap;
                r_frame_start <= w_v_wrap;
                if (w_v_wrap) begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    assign o_hcount      = r_hcount;
    assign o_vcount      = r_vcount;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_hblnk       = r_hblnk;
    assign o_vblnk       = r_vblnk;
    assign o_line_start  = r_line_start;
    assign o_frame_start = r_frame_start;
    assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 1024x768 mode (first lines, hold, mid-line reset)
// and a tiny positive-polarity mode with FRAME_W=2 (full frames, wrap, half-rate ce).
module tb_vga_timing_gen;

    // Instance A: default parameters
    localparam int HA_A = 1024, HF_A = 24, HS_A = 136, HB_A = 160;
    localparam int VA_A = 768,  VF_A = 3,  VS_A = 6,   VB_A = 29;
    localparam int HT_A = HA_A + HF_A + HS_A + HB_A;
    localparam int VT_A = VA_A + VF_A + VS_A + VB_A;

    // Instance B: small mode, positive polarities, 2-bit frame counter
    localparam int HA_B = 8, HF_B = 1, HS_B = 2, HB_B = 1;
    localparam int VA_B = 4, VF_B = 1, VS_B = 1, VB_B = 1;
    localparam int HT_B = HA_B + HF_B + HS_B + HB_B;
    localparam int VT_B = VA_B + VF_B + VS_B + VB_B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, ce_a, rst_b, ce_b;
    logic [10:0] a_h, a_v;
    logic        a_hs, a_vs, a_hb, a_vb, a_ls, a_fs;
    logic [15:0] a_fc;
    logic [3:0]  b_h, b_v;
    logic        b_hs, b_vs, b_hb, b_vb, b_ls, b_fs;
    logic [1:0]  b_fc;

    vga_timing_gen u_a (
        .i_clk(clk), .i_rst(rst_a), .i_ce(ce_a),
        .o_hcount(a_h), .o_vcount(a_v), .o_hsync(a_hs), .o_vsync(a_vs),
        .o_hblnk(a_hb), .o_vblnk(a_vb), .o_line_start(a_ls),
        .o_frame_start(a_fs), .o_frame_cnt(a_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA_B), .H_FP(HF_B), .H_SYNC(HS_B), .H_BP(HB_B),
        .V_ACTIVE(VA_B), .V_FP(VF_B), .V_SYNC(VS_B), .V_BP(VB_B),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(4), .FRAME_W(2)
    ) u_b (
        .i_clk(clk), .i_rst(rst_b), .i_ce(ce_b),
        .o_hcount(b_h), .o_vcount(b_v), .o_hsync(b_hs), .o_vsync(b_vs),
        .o_hblnk(b_hb), .o_vblnk(b_vb), .o_line_start(b_ls),
        .o_frame_start(b_fs), .o_frame_cnt(b_fc)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit run    = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: position is simply the number of enabled edges since reset.
    int n_a = 0, n_b = 0;
    bit ls_a = 1'b0, ls_b = 1'b0;

    always @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            n_a <= 0; ls_a <= 1'b0;
        end else if (ce_a) begin
            n_a <= n_a + 1; ls_a <= ((n_a + 1) % HT_A == 0);
        end else begin
            ls_a <= 1'b0;
        end
    end

    always @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            n_b <= 0; ls_b <= 1'b0;
        end else if (ce_b) begin
            n_b <= n_b + 1; ls_b <= ((n_b + 1) % HT_B == 0);
        end else begin
            ls_b <= 1'b0;
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (run) begin
            int h, v, f;
            h = n_a % HT_A; v = (n_a / HT_A) % VT_A; f = (n_a / (HT_A * VT_A)) % 65536;
            chk("A.hcount", int'(a_h), h);
            chk("A.vcount", int'(a_v), v);
            chk("A.hsync", int'(a_hs), (h >= HA_A + HF_A && h < HA_A + HF_A + HS_A) ? 0 : 1);
            chk("A.vsync", int'(a_vs), (v >= VA_A + VF_A && v < VA_A + VF_A + VS_A) ? 0 : 1);
            chk("A.hblnk", int'(a_hb), int'(h >= HA_A));
            chk("A.vblnk", int'(a_vb), int'(v >= VA_A));
            chk("A.line_start", int'(a_ls), int'(ls_a));
            chk("A.frame_start", int'(a_fs), int'(ls_a && v == 0));
            chk("A.frame_cnt", int'(a_fc), f);
            h = n_b % HT_B; v = (n_b / HT_B) % VT_B; f = (n_b / (HT_B * VT_B)) % 4;
            chk("B.hcount", int'(b_h), h);
            chk("B.vcount", int'(b_v), v);
            chk("B.hsync", int'(b_hs), (h >= HA_B + HF_B && h < HA_B + HF_B + HS_B) ? 1 : 0);
            chk("B.vsync", int'(b_vs), (v >= VA_B + VF_B && v < VA_B + VF_B + VS_B) ? 1 : 0);
            chk("B.hblnk", int'(b_hb), int'(h >= HA_B));
            chk("B.vblnk", int'(b_vb), int'(v >= VA_B));
            chk("B.line_start", int'(b_ls), int'(ls_b));
            chk("B.frame_start", int'(b_fs), int'(ls_b && v == 0));
            chk("B.frame_cnt", int'(b_fc), f);
        end
    end

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        int fs_idx[$];
        rst_a = 1'b1; rst_b = 1'b1; ce_a = 1'b0; ce_b = 1'b0;
        run = 1'b1;
        step(2);
        chk("A.reset.hsync", int'(a_hs), 1);
        chk("B.reset.hsync", int'(b_hs), 0);
        chk("B.reset.vsync", int'(b_vs), 0);
        chk("A.reset.frame_cnt", int'(a_fc), 0);
        rst_a = 1'b0; rst_b = 1'b0; ce_a = 1'b1;

        // Default mode, first line and wrap into line 1
        step(1024); chk("A.n1024.hcount", int'(a_h), 1024); chk("A.n1024.hblnk", int'(a_hb), 1);
        step(23);   chk("A.n1047.hsync", int'(a_hs), 1);
        step(1);    chk("A.n1048.hsync", int'(a_hs), 0);
        step(135);  chk("A.n1183.hsync", int'(a_hs), 0);
        step(1);    chk("A.n1184.hsync", int'(a_hs), 1);
        step(159);  chk("A.n1343.hcount", int'(a_h), 1343); chk("A.n1343.ls", int'(a_ls), 0);
        step(1);    chk("A.n1344.hcount", int'(a_h), 0); chk("A.n1344.vcount", int'(a_v), 1);
                    chk("A.n1344.ls", int'(a_ls), 1); chk("A.n1344.fs", int'(a_fs), 0);
        step(1);    chk("A.n1345.ls", int'(a_ls), 0);

        // Hold with ce=0
        ce_a = 1'b0;
        step(5);    chk("A.hold.hcount", int'(a_h), 1); chk("A.hold.vcount", int'(a_v), 1);
        ce_a = 1'b1;
        step(499);  chk("A.mid.hcount", int'(a_h), 500);

        // Asynchronous reset mid-line
        #2 rst_a = 1'b1;
        #1;
        chk("A.rst.hcount", int'(a_h), 0);
        chk("A.rst.vcount", int'(a_v), 0);
        chk("A.rst.hsync", int'(a_hs), 1);
        chk("A.rst.hblnk", int'(a_hb), 0);
        chk("A.rst.ls", int'(a_ls), 0);
        chk("A.rst.frame_cnt", int'(a_fc), 0);
        step(2);
        rst_a = 1'b0;
        step(1);    chk("A.post_rst.hcount", int'(a_h), 1); chk("A.post_rst.ls", int'(a_ls), 0);
                    chk("A.post_rst.fs", int'(a_fs), 0);
        ce_a = 1'b0;

        // Small mode, full frames
        ce_b = 1'b1;
        step(9);    chk("B.n9.hsync", int'(b_hs), 1); chk("B.n9.hcount", int'(b_h), 9);
        step(2);    chk("B.n11.hsync", int'(b_hs), 0);
        step(1);    chk("B.n12.vcount", int'(b_v), 1); chk("B.n12.ls", int'(b_ls), 1);
        step(36);   chk("B.n48.vblnk", int'(b_vb), 1); chk("B.n48.vcount", int'(b_v), 4);
        step(12);   chk("B.n60.vsync", int'(b_vs), 1);
        step(12);   chk("B.n72.vsync", int'(b_vs), 0);
        step(12);   chk("B.n84.fs", int'(b_fs), 1); chk("B.n84.frame_cnt", int'(b_fc), 1);
                    chk("B.n84.hcount", int'(b_h), 0); chk("B.n84.vcount", int'(b_v), 0);
        step(168);  chk("B.n252.frame_cnt", int'(b_fc), 3);
        step(84);   chk("B.n336.frame_cnt", int'(b_fc), 0); chk("B.n336.fs", int'(b_fs), 1);

        // Half-rate enable: frame period doubles to 168 clocks
        for (int i = 0; i < 336; i++) begin
            ce_b = (i % 2 == 0);
            @(negedge clk);
            if (b_fs) fs_idx.push_back(i);
        end
        ce_b = 1'b0;
        chk("B.half.fs_count", fs_idx.size(), 2);
        if (fs_idx.size() == 2) begin
            chk("B.half.first_fs", fs_idx[0], 166);
            chk("B.half.period", fs_idx[1] - fs_idx[0], 168);
        end
        chk("B.half.frame_cnt", int'(b_fc), 2);
        step(3);

        run = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
